// File: rtl/note_lane_pkg.sv
// note_lane_pkg: shared types and helpers for the note lane scroller.
//   state_t : scroller FSM states (IDLE, PLAY, DONE)
//   pos_w() : width of the step counter for a given song length
package note_lane_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Step counter width; a song must be at least two notes long.
  function automatic int unsigned pos_w(input int unsigned song_len);
    return $clog2(song_len);
  endfunction

endpackage

// File: rtl/note_lane.sv
// note_lane: one lane of the note scroller.
//   Holds the lane pattern in a left-shifting register, clears the note at
//   the judge position on a hit, and flags a miss when a note leaves the
//   judge position unhit. With NOTE_LANE_LOOP_EN defined, a rotating shadow
//   copy of the loaded pattern supplies the fill bit so loops replay the
//   original song regardless of hits.
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_load           capture i_load_pat (wins over step/hit)
//   i_load_pat       lane pattern, MSB plays first
//   i_step           advance one note (already gated to PLAY)
//   i_hit            clear judge note (already gated to PLAY)
//   i_loop           use the shadow MSB as fill bit (loop build only)
//   o_window         visible slice of the pattern
//   o_judge          note at the judge position
//   o_miss           registered one-cycle miss pulse
module note_lane
  import note_lane_pkg::*;
#(
  parameter int unsigned SONG_LEN = 100,
  parameter int unsigned WINDOW   = 10,
  parameter int unsigned JUDGE    = 0
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_load,
  input  logic [SONG_LEN-1:0] i_load_pat,
  input  logic                i_step,
  input  logic                i_hit,
  input  logic                i_loop,
  output logic [WINDOW-1:0]   o_window,
  output logic                o_judge,
  output logic                o_miss
);

  // Register bit that sits under the judge position of the window.
  localparam int unsigned JP = SONG_LEN - WINDOW + JUDGE;

  logic [SONG_LEN-1:0] r_pat;
  logic                r_miss;
  logic [SONG_LEN-1:0] w_cleared;
  logic                w_fill;

  // Hit clears before the shift so a cleared note never reports a miss.
  always_comb begin
    w_cleared = r_pat;
    if (i_hit) w_cleared[JP] = 1'b0;
  end

`ifdef NOTE_LANE_LOOP_EN
  logic [SONG_LEN-1:0] r_shadow;

  assign w_fill = i_loop & r_shadow[SONG_LEN-1];

  // Shadow rotates in lockstep with the lane so its MSB is the next note to refill.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shadow <= '0;
    end else if (i_load) begin
      r_shadow <= i_load_pat;
    end else if (i_step) begin
      r_shadow <= {r_shadow[SONG_LEN-2:0], r_shadow[SONG_LEN-1]};
    end
  end
`else
  logic w_unused_loop;

  assign w_unused_loop = i_loop;
  assign w_fill        = 1'b0;
`endif

  // Lane pattern and miss pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pat  <= '0;
      r_miss <= 1'b0;
    end else if (i_load) begin
      r_pat  <= i_load_pat;
      r_miss <= 1'b0;
    end else begin
      r_miss <= 1'b0;
      if (i_step) begin
        r_pat  <= {w_cleared[SONG_LEN-2:0], w_fill};
        r_miss <= r_pat[JP] & ~i_hit;
      end else if (i_hit) begin
        r_pat  <= w_cleared;
      end
    end
  end

  assign o_window = r_pat[SONG_LEN-1 -: WINDOW];
  assign o_judge  = r_pat[JP];
  assign o_miss   = r_miss;

endmodule

// File: rtl/note_lane_shifter.sv
// note_lane_shifter: multi-lane note scroller for the rhythm game.
//   Owns the IDLE/PLAY/DONE sequencer, the step counter and the done/busy
//   flags; instantiates one note_lane per lane. Optional looping is enabled
//   by defining NOTE_LANE_LOOP_EN; otherwise loop_en is ignored and the song
//   always ends in DONE.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   step         advance pulse from the rate divider
//   load         capture load_data and start playing (from any state)
//   load_data    lane l = [l*SONG_LEN +: SONG_LEN], MSB plays first
//   loop_en      restart instead of finishing (loop build only)
//   hit          per-lane clear of the judge note
//   window       lane l = [l*WINDOW +: WINDOW]
//   judge        per-lane judge bit
//   miss         per-lane one-cycle miss pulse
//   busy         high in PLAY
//   done         one-cycle pulse on song completion
//   pos          steps taken since load
module note_lane_shifter
  import note_lane_pkg::*;
#(
  parameter int unsigned LANES    = 3,
  parameter int unsigned SONG_LEN = 100,
  parameter int unsigned WINDOW   = 10,
  parameter int unsigned JUDGE    = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        step,
  input  logic                        load,
  input  logic [LANES*SONG_LEN-1:0]   load_data,
  input  logic                        loop_en,
  input  logic [LANES-1:0]            hit,
  output logic [LANES*WINDOW-1:0]     window,
  output logic [LANES-1:0]            judge,
  output logic [LANES-1:0]            miss,
  output logic                        busy,
  output logic                        done,
  output logic [pos_w(SONG_LEN)-1:0]  pos
);

  localparam int unsigned POS_W = pos_w(SONG_LEN);

  state_t           r_state;
  logic [POS_W-1:0] r_pos;
  logic             r_busy;
  logic             r_done;

  logic             w_play;
  logic             w_step;
  logic [LANES-1:0] w_hit;
  logic             w_last;
  logic             w_loop_now;

  // Load wins over step/hit; step and hit only act while playing.
  assign w_play = (r_state == ST_PLAY);
  assign w_step = w_play & step & ~load;
  assign w_hit  = hit & {LANES{w_play & ~load}};
  assign w_last = (r_pos == POS_W'(SONG_LEN - 1));

`ifdef NOTE_LANE_LOOP_EN
  assign w_loop_now = loop_en;
`else
  assign w_loop_now = 1'b0;
`endif

  // Sequencer, step counter and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_pos   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (load) begin
        r_state <= ST_PLAY;
        r_pos   <= '0;
        r_busy  <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: r_state <= ST_IDLE;
          ST_PLAY: begin
            if (w_step) begin
              if (!w_last) begin
                r_pos <= r_pos + POS_W'(1);
              end else if (w_loop_now) begin
                r_pos <= '0;
              end else begin
                // pos holds at SONG_LEN-1 once the song has finished
                r_state <= ST_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
          ST_DONE: r_state <= ST_DONE;
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign pos  = r_pos;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    note_lane #(
      .SONG_LEN (SONG_LEN),
      .WINDOW   (WINDOW),
      .JUDGE    (JUDGE)
    ) u_lane (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_load     (load),
      .i_load_pat (load_data[l*SONG_LEN +: SONG_LEN]),
      .i_step     (w_step),
      .i_hit      (w_hit[l]),
      .i_loop     (loop_en),
      .o_window   (window[l*WINDOW +: WINDOW]),
      .o_judge    (judge[l]),
      .o_miss     (miss[l])
    );
  end

endmodule

// File: tb/tb_note_lane_shifter.sv
// Directed bench for note_lane_shifter (1 lane, 8-note song, 4-note window).
module tb_note_lane_shifter;

  localparam int unsigned LANES    = 1;
  localparam int unsigned SONG_LEN = 8;
  localparam int unsigned WINDOW   = 4;
  localparam int unsigned JUDGE    = 0;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      step;
  logic                      load;
  logic [LANES*SONG_LEN-1:0] load_data;
  logic                      loop_en;
  logic [LANES-1:0]          hit;
  logic [LANES*WINDOW-1:0]   window;
  logic [LANES-1:0]          judge;
  logic [LANES-1:0]          miss;
  logic                      busy;
  logic                      done;
  logic [2:0]                pos;

  note_lane_shifter #(
    .LANES    (LANES),
    .SONG_LEN (SONG_LEN),
    .WINDOW   (WINDOW),
    .JUDGE    (JUDGE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .step      (step),
    .load      (load),
    .load_data (load_data),
    .loop_en   (loop_en),
    .hit       (hit),
    .window    (window),
    .judge     (judge),
    .miss      (miss),
    .busy      (busy),
    .done      (done),
    .pos       (pos)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] win;
    logic       j;
    logic       m;
    logic       b;
    logic       d;
    logic [2:0] p;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic exp_t mk(input logic [3:0] win, input logic j, input logic m,
                              input logic b, input logic d, input logic [2:0] p);
    exp_t e;
    e.win = win; e.j = j; e.m = m; e.b = b; e.d = d; e.p = p;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Drive one cycle of inputs, queue the expected outputs, then pop and compare.
  task automatic cyc(input string tag, input logic i_rst, input logic i_step,
                     input logic i_hit, input logic i_load, input exp_t e);
    exp_t x;
    @(negedge clk);
    reset = i_rst; step = i_step; hit = i_hit; load = i_load;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    reset = 1'b0; step = 1'b0; hit = '0; load = 1'b0;
    x = sbq.pop_front();
    chk({tag, ".window"}, 32'(window), 32'(x.win));
    chk({tag, ".judge"},  32'(judge),  32'(x.j));
    chk({tag, ".miss"},   32'(miss),   32'(x.m));
    chk({tag, ".busy"},   32'(busy),   32'(x.b));
    chk({tag, ".done"},   32'(done),   32'(x.d));
    chk({tag, ".pos"},    32'(pos),    32'(x.p));
  endtask

  logic [3:0] t_win  [8];
  logic       t_miss [8];

  initial begin
    reset = 1'b1; step = 1'b0; load = 1'b0; hit = '0;
    load_data = 8'b1011_0001;
`ifdef NOTE_LANE_LOOP_EN
    loop_en = 1'b1;
`else
    loop_en = 1'b0;
`endif

    // Reset and ignored inputs in IDLE
    cyc("rst0", 1'b1, 1'b0, 1'b0, 1'b0, mk(4'b0000, 0, 0, 0, 0, 3'd0));
    cyc("rst1", 1'b1, 1'b0, 1'b0, 1'b0, mk(4'b0000, 0, 0, 0, 0, 3'd0));
    cyc("idle_step", 1'b0, 1'b1, 1'b0, 1'b0, mk(4'b0000, 0, 0, 0, 0, 3'd0));
    cyc("idle_hit",  1'b0, 1'b0, 1'b1, 1'b0, mk(4'b0000, 0, 0, 0, 0, 3'd0));

    // Load, then a step without a hit
    cyc("load",     1'b0, 1'b0, 1'b0, 1'b1, mk(4'b1011, 1, 0, 1, 0, 3'd0));
    cyc("step_nh",  1'b0, 1'b1, 1'b0, 1'b0, mk(4'b0110, 0, 1, 1, 0, 3'd1));
    cyc("miss_end", 1'b0, 1'b0, 1'b0, 1'b0, mk(4'b0110, 0, 0, 1, 0, 3'd1));

    // Load with step ignored, then hit together with step
    cyc("load_st",  1'b0, 1'b1, 1'b1, 1'b1, mk(4'b1011, 1, 0, 1, 0, 3'd0));
    cyc("hit_step", 1'b0, 1'b1, 1'b1, 1'b0, mk(4'b0100, 0, 0, 1, 0, 3'd1));
    cyc("hit_idle", 1'b0, 1'b0, 1'b0, 1'b0, mk(4'b0100, 0, 0, 1, 0, 3'd1));

`ifdef NOTE_LANE_LOOP_EN
    // Looping: hit on the first step, the eighth step restores the original song
    t_win  = '{4'b0100, 4'b1000, 4'b0000, 4'b0001, 4'b0011, 4'b0110, 4'b1101, 4'b1011};
    t_miss = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    cyc("loop_load", 1'b0, 1'b0, 1'b0, 1'b1, mk(4'b1011, 1, 0, 1, 0, 3'd0));
    for (int k = 0; k < 8; k++) begin
      cyc($sformatf("loop_s%0d", k + 1), 1'b0, 1'b1, (k == 0), 1'b0,
          mk(t_win[k], t_win[k][0], t_miss[k], 1'b1, 1'b0, 3'((k + 1) % 8)));
    end
`else
    // Full song without looping: done on the eighth step, ninth step ignored
    t_win  = '{4'b0110, 4'b1100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    t_miss = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    cyc("end_load", 1'b0, 1'b0, 1'b0, 1'b1, mk(4'b1011, 1, 0, 1, 0, 3'd0));
    for (int k = 0; k < 8; k++) begin
      cyc($sformatf("end_s%0d", k + 1), 1'b0, 1'b1, 1'b0, 1'b0,
          mk(t_win[k], t_win[k][0], t_miss[k], (k != 7), (k == 7), (k == 7) ? 3'd7 : 3'(k + 1)));
    end
    cyc("end_s9",  1'b0, 1'b1, 1'b0, 1'b0, mk(4'b0000, 0, 0, 0, 0, 3'd7));
    cyc("done_hit", 1'b0, 1'b0, 1'b1, 1'b0, mk(4'b0000, 0, 0, 0, 0, 3'd7));
`endif

    // Reset mid-song after three steps, then a step in IDLE
    cyc("mid_load", 1'b0, 1'b0, 1'b0, 1'b1, mk(4'b1011, 1, 0, 1, 0, 3'd0));
    cyc("mid_s1",   1'b0, 1'b1, 1'b0, 1'b0, mk(4'b0110, 0, 1, 1, 0, 3'd1));
    cyc("mid_s2",   1'b0, 1'b1, 1'b0, 1'b0, mk(4'b1100, 0, 0, 1, 0, 3'd2));
    cyc("mid_s3",   1'b0, 1'b1, 1'b0, 1'b0, mk(4'b1000, 0, 0, 1, 0, 3'd3));
    cyc("mid_rst",  1'b1, 1'b1, 1'b0, 1'b0, mk(4'b0000, 0, 0, 0, 0, 3'd0));
    cyc("post_rst", 1'b0, 1'b1, 1'b0, 1'b0, mk(4'b0000, 0, 0, 0, 0, 3'd0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
